axi_lsu_master: RTL and testbench

- Upstream neighbour of the simulation SRAM slave. Converts the core's single-request load/store interface into the five AXI-lite master channels (AR/R/AW/W/B) that the SRAM slave consumes.
- One transaction is outstanding at a time.
- Returns read data or write completion to the core as a one-cycle response pulse.
- A watchdog counter turns a hung slave into an error response.

---
 rtl/axi_lsu_master.sv | 132 +++++++++++++
 tb/tb_axi_lsu_master.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lsu_master.sv
// Single-outstanding load/store to AXI-lite master bridge.
// One request in flight; a watchdog forces an error response if the slave hangs.
module axi_lsu_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 1023
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wmask,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_W-1:0]     araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_W-1:0]     awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);
  localparam int STRB_W = DATA_W / 8;
  localparam int WD_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP, DONE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [STRB_W-1:0]   wmask_q;
  logic                aw_done, w_done, err_q;
  logic [WD_W-1:0]     wdog;
  logic                waiting, tmo, aw_hs, w_hs, aw_all, w_all;

  always_comb begin
    waiting = (state == RADDR) || (state == RDATA) || (state == WRITE) || (state == WRESP);
    // fires on the TIMEOUT-th cycle spent in one wait state; a handshake that cycle still wins
    tmo     = waiting && (wdog >= WD_W'(TIMEOUT - 1));
    aw_hs   = awvalid && awready;
    w_hs    = wvalid && wready;
    aw_all  = aw_done || aw_hs;
    w_all   = w_done || w_hs;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = req_wen ? WRITE : RADDR;
      RADDR:   if (arready) state_nxt = RDATA;
               else if (tmo) state_nxt = DONE;
      RDATA:   if (rvalid || tmo) state_nxt = DONE;
      WRITE:   if (aw_all && w_all) state_nxt = WRESP;
               else if (tmo) state_nxt = DONE;
      WRESP:   if (bvalid || tmo) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    arvalid    = (state == RADDR);
    rready     = (state == RDATA);
    awvalid    = (state == WRITE) && !aw_done;
    wvalid     = (state == WRITE) && !w_done;
    bready     = (state == WRESP);
    resp_valid = (state == DONE);
    araddr     = addr_q;
    awaddr     = addr_q;
    wdata      = wdata_q;
    wstrb      = wmask_q;
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      wdog    <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (state == WRITE) begin
        aw_done <= aw_all;
        w_done  <= w_all;
      end
      if (state_nxt != state)                     wdog <= '0;
      else if (waiting && wdog != WD_W'(TIMEOUT)) wdog <= wdog + 1'b1;
      if (state == RDATA && rvalid) begin
        rdata_q <= rdata;
        err_q   <= |rresp;
      end else if (state == WRESP && bvalid) begin
        rdata_q <= '0;
        err_q   <= |bresp;
      end else if (tmo && state_nxt == DONE) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axi_lsu_master.sv
// Bench for axi_lsu_master: programmable-latency AXI-lite slave plus a
// stage-count reference model predicting response, latency and per-channel valid cycles.
module tb_axi_lsu_master;
  localparam int AW = 32, DW = 64, SW = 8, TO = 8;

  logic          aclk = 1'b0, areset = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_wen = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [SW-1:0] req_wmask = '0;
  logic          resp_valid, resp_err;
  logic [DW-1:0] resp_rdata;
  logic [AW-1:0] araddr, awaddr;
  logic          arvalid, arready, rvalid, rready, awvalid, awready;
  logic          wvalid, wready, bvalid, bready;
  logic [DW-1:0] rdata, wdata;
  logic [1:0]    rresp, bresp;
  logic [SW-1:0] wstrb;

  int checks = 0, errors = 0;

  // slave configuration: cycles of ready-low per channel, cycles before R/B valid
  int            ar_d, aw_d, w_d, r_d, b_d;
  logic [1:0]    rr_cfg, br_cfg;
  logic [DW-1:0] rd_cfg;

  axi_lsu_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave updates on the falling edge; p_* hold the master outputs seen on the
  // previous falling edge, i.e. the values present at the rising edge in between.
  initial begin
    int ar_c, aw_c, w_c, r_c, b_c;
    bit r_pend, b_pend, aw_got, w_got, p_arv, p_rr, p_awv, p_wv, p_br;
    forever begin
      @(negedge aclk or posedge areset);
      if (areset) begin
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        rdata = '0; rresp = 0; bresp = 0;
        ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        p_arv = 0; p_rr = 0; p_awv = 0; p_wv = 0; p_br = 0;
      end else begin
        if (p_rr && rvalid) rvalid = 0;
        if (p_br && bvalid) bvalid = 0;
        if (p_arv && arready) begin r_pend = 1; r_c = r_d; end
        if (p_awv && awready) aw_got = 1;
        if (p_wv && wready) w_got = 1;
        if (aw_got && w_got) begin b_pend = 1; b_c = b_d; aw_got = 0; w_got = 0; end
        if (r_pend) begin
          if (r_c == 0) begin rvalid = 1; rdata = rd_cfg; rresp = rr_cfg; r_pend = 0; end
          else r_c--;
        end
        if (b_pend) begin
          if (b_c == 0) begin bvalid = 1; bresp = br_cfg; b_pend = 0; end
          else b_c--;
        end
        arready = arvalid && ar_c >= ar_d; ar_c = arvalid ? ar_c + 1 : 0;
        awready = awvalid && aw_c >= aw_d; aw_c = awvalid ? aw_c + 1 : 0;
        wready  = wvalid && w_c >= w_d;    w_c  = wvalid ? w_c + 1 : 0;
        // an abandoned (timed-out) transfer must not leak into the next one
        if (resp_valid) begin
          r_pend = 0; b_pend = 0; rvalid = 0; bvalid = 0; aw_got = 0; w_got = 0;
        end
        p_arv = arvalid; p_rr = rready; p_awv = awvalid; p_wv = wvalid; p_br = bready;
      end
    end
  end

  function automatic int stage(input int d);
    return (d >= TO) ? TO : d + 1;
  endfunction

  task automatic run_txn(input bit wen, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [SW-1:0] wm, input int ard, input int awd, input int wdd,
                         input int rd, input int bd, input logic [1:0] rr, input logic [1:0] br,
                         input logic [DW-1:0] rdat);
    int n, arc, awc, wc, bc, m, s1, s2, e_lat, e_arc, e_awc, e_wc, e_bc;
    bit got, stable_ok, busy_ok, to, e_err;
    logic [DW-1:0] g_rdata, e_rdata;
    logic g_err;
    @(posedge aclk); #1;
    ar_d = ard; aw_d = awd; w_d = wdd; r_d = rd; b_d = bd;
    rr_cfg = rr; br_cfg = br; rd_cfg = rdat;
    req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wmask = wm;
    @(negedge aclk);
    chk("req_ready_idle", req_ready, 1);
    @(posedge aclk); #1;
    req_valid = 0;
    req_wen = 1'($urandom); req_addr = $urandom; req_wdata = {$urandom, $urandom};
    req_wmask = 8'($urandom);
    n = 1; arc = 0; awc = 0; wc = 0; bc = 0; got = 0; stable_ok = 1; busy_ok = 1;
    g_rdata = '0; g_err = 0;
    while (n < 60 && !got) begin
      @(negedge aclk); n++;
      if (arvalid) begin arc++; if (araddr !== addr) stable_ok = 0; end
      if (awvalid) begin awc++; if (awaddr !== addr) stable_ok = 0; end
      if (wvalid) begin wc++; if (wdata !== wd || wstrb !== wm) stable_ok = 0; end
      if (bvalid && bready) bc++;
      if (resp_valid) begin got = 1; g_rdata = resp_rdata; g_err = resp_err; end
      else if (req_ready) busy_ok = 0;
    end
    if (!wen) begin
      to = ard >= TO; s1 = stage(ard); s2 = 0;
      if (!to) begin s2 = stage(rd); to = rd >= TO; end
      e_arc = s1; e_awc = 0; e_wc = 0; e_bc = 0;
      e_rdata = to ? '0 : rdat; e_err = to || rr != 0;
    end else begin
      m = (awd > wdd) ? awd : wdd;
      to = m >= TO; s1 = stage(m); s2 = 0;
      if (!to) begin s2 = stage(bd); to = bd >= TO; end
      e_arc = 0; e_awc = stage(awd); e_wc = stage(wdd); e_bc = to ? 0 : 1;
      e_rdata = '0; e_err = to || br != 0;
    end
    // latency counted inclusively from the handshake cycle to the pulse cycle
    e_lat = 2 + s1 + s2;
    chk("resp_seen", got, 1);
    chk("latency", n, e_lat);
    chk("resp_rdata", g_rdata, e_rdata);
    chk("resp_err", g_err, e_err);
    chk("ar_cycles", arc, e_arc);
    chk("aw_cycles", awc, e_awc);
    chk("w_cycles", wc, e_wc);
    chk("b_handshakes", bc, e_bc);
    chk("chan_stable", stable_ok, 1);
    chk("req_ready_busy", busy_ok, 0 == 0);
    @(negedge aclk);
    chk("resp_one_pulse", resp_valid, 0);
    chk("req_ready_after", req_ready, 1);
  endtask

  task automatic reset_in_wresp();
    bit seen, rsp;
    @(posedge aclk); #1;
    ar_d = 0; aw_d = 0; w_d = 0; r_d = 0; b_d = 6; rr_cfg = 0; br_cfg = 0; rd_cfg = '0;
    req_valid = 1; req_wen = 1; req_addr = 32'h80000020; req_wdata = 64'h55; req_wmask = 8'hFF;
    @(posedge aclk); #1;
    req_valid = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (bready) begin seen = 1; break; end
    end
    chk("rst_reach_wresp", seen, 1);
    #2 areset = 1;
    #1;
    chk("rst_bready", bready, 0);
    chk("rst_chan_valids", {arvalid, rready, awvalid, wvalid}, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    rsp = 0;
    repeat (3) begin @(negedge aclk); if (resp_valid) rsp = 1; end
    areset = 0;
    repeat (4) begin @(negedge aclk); if (resp_valid) rsp = 1; end
    chk("rst_no_resp", rsp, 0);
  endtask

  initial begin
    int ard, awd, wdd, rd, bd;
    bit wen;
    ar_d = 0; aw_d = 0; w_d = 0; r_d = 0; b_d = 0; rr_cfg = 0; br_cfg = 0; rd_cfg = '0;
    repeat (3) @(negedge aclk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_valids", {arvalid, rready, awvalid, wvalid, bready, resp_valid}, 0);
    chk("reset_rdata", resp_rdata, 0);
    chk("reset_err", resp_err, 0);
    chk("reset_addr", araddr, 0);
    areset = 0;

    run_txn(0, 32'h80000008, '0, '0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 64'h1122334455667788);
    run_txn(1, 32'h80000010, 64'hDEADBEEF, 8'h0F, 0, 2, 0, 0, 0, 2'b00, 2'b00, '0);
    run_txn(0, 32'h80000040, '0, '0, 5, 0, 0, 0, 0, 2'b00, 2'b00, 64'hA5A5);
    run_txn(0, 32'h80000048, '0, '0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 64'h77);
    run_txn(1, 32'h80000050, 64'h1234, 8'hF0, 0, 0, 3, 0, 2, 2'b00, 2'b11, '0);
    run_txn(0, 32'h80000060, '0, '0, 20, 0, 0, 0, 0, 2'b00, 2'b00, 64'h99);
    run_txn(0, 32'h80000068, '0, '0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 64'hCAFE);
    run_txn(1, 32'h80000070, 64'h1, 8'h01, 0, 7, 7, 0, 7, 2'b00, 2'b00, '0);
    reset_in_wresp();
    run_txn(0, 32'h80000078, '0, '0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 64'h0BADF00D);

    for (int t = 0; t < 40; t++) begin
      wen = 1'($urandom);
      ard = $urandom_range(0, 3); awd = $urandom_range(0, 3); wdd = $urandom_range(0, 3);
      rd = $urandom_range(0, 3); bd = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: ard = $urandom_range(8, 10);
          1: rd  = $urandom_range(8, 10);
          2: awd = $urandom_range(8, 10);
          default: bd = $urandom_range(8, 10);
        endcase
      end
      run_txn(wen, $urandom, {$urandom, $urandom}, 8'($urandom), ard, awd, wdd, rd, bd,
              2'($urandom), 2'($urandom), {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
